// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator with pixel-rate prescaler, h/v counters and syncs
module vga_sync_gen #(
  parameter int TICK_DIV  = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       pixel_tick,
  output logic [9:0] pixelx,
  output logic [9:0] pixely,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int PW       = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
  localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSS = 10'(HS_START);
  localparam logic [9:0] HSE = 10'(HS_START + H_SYNC - 1);
  localparam logic [9:0] VSS = 10'(VS_START);
  localparam logic [9:0] VSE = 10'(VS_START + V_SYNC - 1);
  localparam logic [9:0] HV  = 10'(H_VISIBLE);
  localparam logic [9:0] VV  = 10'(V_VISIBLE);
  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || TICK_DIV < 1) begin : g_bad_params
      $error("vga_sync_gen: timing totals exceed 10-bit counters or TICK_DIV < 1");
    end
  endgenerate
  logic [PW-1:0] ps, ps_n;
  logic [9:0] nx, ny;
  logic hwrap;
  always_comb begin
    ps_n  = ps == PS_MAX ? '0 : ps + 1'b1;
    hwrap = pixelx == HT1;
    nx    = pixel_tick ? (hwrap ? '0 : pixelx + 1'b1) : pixelx;
    ny    = pixel_tick && hwrap ? (pixely == VT1 ? '0 : pixely + 1'b1) : pixely;
  end
  // syncs come from next-state counters so they line up with pixelx/pixely
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ps          <= '0;
      pixel_tick  <= 1'b0;
      pixelx      <= '0;
      pixely      <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      ps          <= ps_n;
      pixel_tick  <= ps_n == PS_MAX;
      pixelx      <= nx;
      pixely      <= ny;
      hsync       <= !(nx >= HSS && nx <= HSE);
      vsync       <= !(ny >= VSS && ny <= VSE);
      frame_start <= pixel_tick && hwrap && pixely == VT1;
    end
  end
  assign video_on = pixelx < HV && pixely < VV;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench; per-tick expectations queued, monitors pop on pixel_tick
module tb_vga_sync_gen;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic hs, vs, vo, fs;
  } exp_t;

  logic clk = 0;
  always #5 clk = ~clk;
  logic rst0_n = 0, rst1_n = 0;
  logic on0 = 0, on1 = 0;
  int total = 0, bad = 0;
  exp_t q0[$], q1[$];

  logic t0, hs0, vs0, vo0, fs0, t1, hs1, vs1, vo1, fs1, t2, hs2, vs2, vo2, fs2;
  logic [9:0] x0, y0, x1, y1, x2, y2;

  vga_sync_gen u0 (.clock(clk), .reset_n(rst0_n), .pixel_tick(t0), .pixelx(x0), .pixely(y0),
                   .hsync(hs0), .vsync(vs0), .video_on(vo0), .frame_start(fs0));
  vga_sync_gen #(.TICK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1))
    u1 (.clock(clk), .reset_n(rst1_n), .pixel_tick(t1), .pixelx(x1), .pixely(y1),
        .hsync(hs1), .vsync(vs1), .video_on(vo1), .frame_start(fs1));
  vga_sync_gen #(.TICK_DIV(1)) u2 (.clock(clk), .reset_n(rst1_n), .pixel_tick(t2), .pixelx(x2),
                   .pixely(y2), .hsync(hs2), .vsync(vs2), .video_on(vo2), .frame_start(fs2));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // expected outputs during the k-th tick after reset release
  function automatic exp_t model(int k, int ht, int vt, int hv, int vv,
                                 int hss, int hse, int vss, int vse, int fper);
    exp_t e;
    int x, y;
    x = k % ht;
    y = (k / ht) % vt;
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.hs = !(x >= hss && x <= hse);
    e.vs = !(y >= vss && y <= vse);
    e.vo = x < hv && y < vv;
    e.fs = fper > 0 && k > 0 && k % fper == 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (t0 && on0) begin
      if (q0.size() == 0) begin
        total++; bad++; on0 = 0;
        $display("FAIL sb0_underflow got=tick want=no_tick");
      end else chk("sb0", {x0, y0, hs0, vs0, vo0, fs0}, 32'(q0.pop_front()));
    end
    if (t1 && on1) begin
      if (q1.size() == 0) begin
        total++; bad++; on1 = 0;
        $display("FAIL sb1_underflow got=tick want=no_tick");
      end else chk("sb1", {x1, y1, hs1, vs1, vo1, fs1}, 32'(q1.pop_front()));
    end
  end

  task automatic drain(input int which, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((which == 0 ? q0.size() : q1.size()) == 0) break;
      @(posedge clk);
    end
    chk(which == 0 ? "drain0_left" : "drain1_left", which == 0 ? q0.size() : q1.size(), 0);
    if (which == 0) on0 = 0; else on1 = 0;
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_tick"}, t0, 0);
    chk({tag, "_x"}, x0, 0);
    chk({tag, "_y"}, y0, 0);
    chk({tag, "_hs"}, hs0, 1);
    chk({tag, "_vs"}, vs0, 1);
    chk({tag, "_vo"}, vo0, 1);
    chk({tag, "_fs"}, fs0, 0);
  endtask

  task automatic start0(input int nticks);
    for (int k = 0; k < nticks; k++) q0.push_back(model(k, 800, 525, 640, 480, 656, 751, 490, 491, 0));
    on0 = 1;
    @(negedge clk) rst0_n = 1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      chk("tick_phase", t0, c % 4 == 3);
      if (c == 4) chk("x_after_first_tick", x0, 1);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 chk_reset0("rst");
    start0(1701);
    drain(0, 8000);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (x0 == 300) break;
    end
    chk("reach_x300", x0, 300);
    @(posedge clk); #2;
    rst0_n = 0;
    #1 chk_reset0("midrst");
    repeat (2) @(posedge clk);
    start0(901);
    drain(0, 5000);

    for (int k = 0; k < 370; k++) q1.push_back(model(k, 15, 8, 8, 4, 10, 12, 5, 6, 120));
    on1 = 1;
    @(negedge clk) rst1_n = 1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      chk("tick1_const", t1, 1);
    end
    drain(1, 500);

    for (int i = 0; i < 2000; i++) begin
      if (y2 == 1) break;
      @(posedge clk); #1;
    end
    chk("u2_row1", y2, 1);
    chk("u2_x0", x2, 0);
    @(posedge clk); #1;
    chk("u2_xstep", x2, 1);
    n = 1;
    for (int i = 0; i < 2000; i++) begin
      if (y2 == 2) break;
      @(posedge clk); #1;
      n++;
    end
    chk("u2_line_period", n, 800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
